// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one 32-bit ALU between two requesters.
// Flow per operation: IDLE (grant/capture) -> EXEC (ALU) -> RESP (hold until consumed).
module alu_share_alu (
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] data_o,
  output logic        zero_o
);
  always_comb begin
    data_o = '0;
    case (op_i)
      4'b0011: data_o = a_i + b_i;
      4'b0001: data_o = a_i - b_i;
      4'b0100: data_o = {b_i[15:0], 16'h0000};
      default: data_o = '0;
    endcase
    zero_o = (data_o == '0);
  end
endmodule

module alu_share_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [3:0]            req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [3:0]            req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_data_o,
  output logic                  rsp0_zero_o,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_data_o,
  output logic                  rsp1_zero_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  id_q, id_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zero_q, zero_d;
  logic                  gnt;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_zero;

  alu_share_alu u_alu (
    .op_i   (op_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .data_o (alu_data),
    .zero_o (alu_zero)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    zero_d       = zero_q;
    gnt          = 1'b0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          // prio only breaks ties; a lone requester always wins
          gnt          = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
          req0_ready_o = ~gnt;
          req1_ready_o = gnt;
          id_d         = gnt;
          op_d         = gnt ? req1_op_i : req0_op_i;
          a_d          = gnt ? req1_a_i  : req0_a_i;
          b_d          = gnt ? req1_b_i  : req0_b_i;
          prio_d       = ~gnt;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_data;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (id_q ? rsp1_ready_i : rsp0_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign rsp0_valid_o = (state_q == RESP) && !id_q;
  assign rsp1_valid_o = (state_q == RESP) &&  id_q;
  assign rsp0_data_o  = res_q;
  assign rsp1_data_o  = res_q;
  assign rsp0_zero_o  = zero_q;
  assign rsp1_zero_o  = zero_q;
  assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed table, corner sequences, random traffic.
module tb_alu_share_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [3:0]  req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic        rsp0_valid_o, rsp0_ready_i, rsp0_zero_o;
  logic        rsp1_valid_o, rsp1_ready_i, rsp1_zero_o;
  logic [31:0] rsp0_data_o, rsp1_data_o;
  logic        busy_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        prio_m;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_data_o(rsp0_data_o),
    .rsp0_zero_o(rsp0_zero_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_data_o(rsp1_data_o),
    .rsp1_zero_o(rsp1_zero_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic        sel;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic        exp_z;
    int unsigned delay;
  } vec_t;

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    if (op == 4'd3) return a + b;
    if (op == 4'd1) return a - b;
    if (op == 4'd4) return b * 32'h10000;
    return 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from the IDLE slot; grant and result come from the model
  // unless explicit expectations are supplied.
  task automatic run_pair(input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                          input logic [31:0] b0, input logic v1, input logic [3:0] op1,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input int unsigned delay, input logic use_exp,
                          input logic [31:0] exp_d_in, input logic exp_z_in);
    logic        g;
    logic [31:0] ed;
    logic        ez;
    g  = (v0 && v1) ? prio_m : v1;
    ed = g ? model_alu(op1, a1, b1) : model_alu(op0, a0, b0);
    ez = (ed == 32'd0);
    if (use_exp) begin
      ed = exp_d_in;
      ez = exp_z_in;
    end
    req0_valid_i = v0; req0_op_i = op0; req0_a_i = a0; req0_b_i = b0;
    req1_valid_i = v1; req1_op_i = op1; req1_a_i = a1; req1_b_i = b1;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_req0_ready", req0_ready_o, v0 && !g);
    chk("idle_req1_ready", req1_ready_o, g);
    step();
    // EXEC: winner drops valid and scrambles its operands; result must not change
    if (g) begin
      req1_valid_i = 1'b0; req1_op_i = 4'($urandom); req1_a_i = $urandom; req1_b_i = $urandom;
    end else begin
      req0_valid_i = 1'b0; req0_op_i = 4'($urandom); req0_a_i = $urandom; req0_b_i = $urandom;
    end
    rsp0_ready_i = (delay == 0);
    rsp1_ready_i = (delay == 0);
    #1;
    chk("exec_busy", busy_o, 1);
    chk("exec_req0_ready", req0_ready_o, 0);
    chk("exec_req1_ready", req1_ready_o, 0);
    chk("exec_rsp0_valid", rsp0_valid_o, 0);
    chk("exec_rsp1_valid", rsp1_valid_o, 0);
    step();
    for (int unsigned i = 0; i <= delay; i++) begin
      chk("resp_rsp0_valid", rsp0_valid_o, !g);
      chk("resp_rsp1_valid", rsp1_valid_o, g);
      chk("resp_data", g ? rsp1_data_o : rsp0_data_o, ed);
      chk("resp_zero", g ? rsp1_zero_o : rsp0_zero_o, ez);
      chk("resp_req_ready", {req0_ready_o, req1_ready_o}, 0);
      chk("resp_busy", busy_o, 1);
      if (i == delay) begin
        rsp0_ready_i = 1'b1;
        rsp1_ready_i = 1'b1;
      end
      step();
    end
    chk("back_idle_busy", busy_o, 0);
    chk("back_idle_rsp_valid", {rsp0_valid_o, rsp1_valid_o}, 0);
    chk("back_idle_loser_ready", g ? req0_ready_o : req1_ready_o, g ? req0_valid_i : req1_valid_i);
    prio_m = ~g;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  task automatic reset_mid(input logic in_resp);
    req0_valid_i = 1'b1; req0_op_i = 4'd3; req0_a_i = 32'd1; req0_b_i = 32'd2;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    step();
    req0_valid_i = 1'b0;
    if (in_resp) begin
      step();
      chk("pre_reset_rsp0_valid", rsp0_valid_o, 1);
    end
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_rsp_valid", {rsp0_valid_o, rsp1_valid_o}, 0);
    chk("async_rst_data", rsp0_data_o, 0);
    chk("async_rst_zero", rsp0_zero_o, 0);
    step();
    reset = 1'b0;
    prio_m = 1'b0;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_rsp", {rsp0_valid_o, rsp1_valid_o, busy_o}, 0);
    end
    // both valid: req0 must win again since prio was cleared
    run_pair(1, 4'd3, 32'd10, 32'd20, 1, 4'd3, 32'd1, 32'd1, 0, 1, 32'd30, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{sel: 0, op: 4'b0011, a: 32'd5,        b: 32'd7,        exp_d: 32'd12,         exp_z: 0, delay: 0};
    vecs[1] = '{sel: 1, op: 4'b0011, a: 32'hFFFFFFFF, b: 32'd1,        exp_d: 32'd0,          exp_z: 1, delay: 10};
    vecs[2] = '{sel: 0, op: 4'b1111, a: 32'd3,        b: 32'd4,        exp_d: 32'd0,          exp_z: 1, delay: 0};
    vecs[3] = '{sel: 1, op: 4'b0001, a: 32'd3,        b: 32'd5,        exp_d: 32'hFFFFFFFE,   exp_z: 0, delay: 1};
    vecs[4] = '{sel: 0, op: 4'b0100, a: 32'hDEAD,     b: 32'hABCD1234, exp_d: 32'h12340000,   exp_z: 0, delay: 0};
    vecs[5] = '{sel: 1, op: 4'b0001, a: 32'd0,        b: 32'd0,        exp_d: 32'd0,          exp_z: 1, delay: 2};

    reset = 1'b1;
    req0_valid_i = 0; req0_op_i = 0; req0_a_i = 0; req0_b_i = 0;
    req1_valid_i = 0; req1_op_i = 0; req1_a_i = 0; req1_b_i = 0;
    rsp0_ready_i = 0; rsp1_ready_i = 0;
    prio_m = 1'b0;
    step();
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", {rsp0_valid_o, rsp1_valid_o}, 0);
    chk("rst_data", rsp0_data_o, 0);
    chk("rst_zero", rsp1_zero_o, 0);
    reset = 1'b0;
    step();
    chk("idle_no_req_ready", {req0_ready_o, req1_ready_o}, 0);

    // contention from reset: req0 first, then req1
    run_pair(1, 4'd1, 32'd9, 32'd9, 1, 4'd4, 32'd0, 32'h1234, 0, 1, 32'd0, 1'b1);
    run_pair(0, 4'd1, 32'd9, 32'd9, 1, 4'd4, 32'd0, 32'h1234, 0, 1, 32'h12340000, 1'b0);
    // after a lone req0 grant, a simultaneous pair goes to req1
    run_pair(1, 4'd3, 32'd1, 32'd1, 0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd2, 1'b0);
    run_pair(1, 4'd3, 32'd1, 32'd1, 1, 4'd3, 32'd40, 32'd2, 0, 1, 32'd42, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].sel)
        run_pair(0, 4'd0, 32'd0, 32'd0, 1, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].delay, 1, vecs[i].exp_d, vecs[i].exp_z);
      else
        run_pair(1, vecs[i].op, vecs[i].a, vecs[i].b, 0, 4'd0, 32'd0, 32'd0,
                 vecs[i].delay, 1, vecs[i].exp_d, vecs[i].exp_z);
    end

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int i = 0; i < 40; i++) begin
      logic        v0, v1;
      logic [3:0]  o0, o1;
      logic [3:0]  opt[4];
      opt[0] = 4'd3; opt[1] = 4'd1; opt[2] = 4'd4; opt[3] = 4'($urandom_range(0, 15));
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      o0 = opt[$urandom_range(0, 3)];
      o1 = opt[$urandom_range(0, 3)];
      run_pair(v0, o0, $urandom, $urandom, v1, o1, $urandom, $urandom,
               $urandom_range(0, 3), 0, 32'd0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
